csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control/status register file that answers the core's CSR access port (strobe, 12-bit address, write data, combinational read data). It holds trap state (mstatus, mtvec, mepc, mcause, mscratch), read-only identity registers, and the free-running 64-bit cycle and retired-instruction counters. It also captures trap entry and `mret` return, and feeds the trap vector and return PC back to the PC-update logic.

## Interface
- `HART_ID`, 0: value returned by mhartid.
- `MTVEC_RESET`, 32'h0000_0000: reset value of mtvec; bits [1:0] are ignored.
- `MISA_VAL`, 32'h4000_0100: value returned by misa (RV32I).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `csr`  in  1  CSR access strobe, valid for one cycle per CSR instruction.
- `csr_rd_addr`  in  12  CSR address, used for both read and write.
- `csr_wr_data`  in  32  new register value, fully computed by the core.
- `csr_rd_data`  out  32  current value of the addressed CSR; combinational.
- `instr_retire`  in  1  one instruction retired this cycle.
- `trap`  in  1  trap entry request.
- `trap_cause`  in  32  cause code to load into mcause.
- `trap_pc`  in  32  PC to load into mepc.
- `mret`  in  1  return-from-trap request.
- `mtvec_o`  out  32  trap target; {mtvec[31:2], 2'b00}.
- `mepc_o`  out  32  return target; {mepc[31:2], 2'b00}.
- `mie_o`  out  1  mstatus.MIE.
- `illegal_csr`  out  1  registered flag: previous-cycle access was to an unmapped address, or was a write to a read-only CSR.

## Operation
- Address map:
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; every other bit reads 0.
  - 0x301 misa: read-only, returns MISA_VAL.
  - 0x305 mtvec: bits [1:0] read 0 (direct mode only).
  - 0x340 mscratch: 32-bit read/write.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause: 32-bit read/write.
  - 0xB00 mcycle, 0xB80 mcycleh: read/write low/high halves of the 64-bit cycle counter.
  - 0xB02 minstret, 0xB82 minstreth: read/write low/high halves of the 64-bit retired-instruction counter.
  - 0xF14 mhartid: read-only, returns HART_ID.
- Read: `csr_rd_data` is a mux on `csr_rd_addr`. It is valid whether or not `csr` is high. Unmapped addresses read 0.
- Write: when `csr` is high, the addressed writable CSR loads `csr_wr_data` at the next rising edge.
  - Writes to read-only or unmapped addresses are discarded.
  - Every `csr` access with a read-only or unmapped address sets `illegal_csr` for exactly the following cycle.
- Counters:
  - mcycle increments by 1 on every clock edge with reset low.
  - minstret increments by 1 on each edge where `instr_retire` is high.
  - Both are 64-bit and wrap from 2^64-1 to 0. A carry out of the low half propagates into the high half.
- Trap entry (`trap` high), in one cycle:
  - mepc <= trap_pc, mcause <= trap_cause.
  - MPIE <= MIE, MIE <= 0.
- mret (`mret` high), in one cycle: MIE <= MPIE, MPIE <= 1.
- Priority, highest first: reset > trap > mret > CSR write > counter increment.
  - A CSR write to mcycle/minstret (either half) replaces that half's increment in the same cycle; the other half is unaffected, and no carry is applied that cycle.
  - If `trap` and `csr` arrive together, the trap updates win on mepc/mcause/mstatus. A write to any other CSR still takes effect.
  - If `trap` and `mret` arrive together, trap wins and mret is ignored.

## Timing
- Reset (sync, one edge):
  - mstatus=0, mepc=0, mcause=0, mscratch=0, mtvec=MTVEC_RESET, all counters=0.
  - illegal_csr=0, mtvec_o={MTVEC_RESET[31:2],2'b00}, mepc_o=0, mie_o=0.
- Reset asserted mid-access: the pending write is dropped and all state takes its reset values.
- Read latency 0: combinational from address to data.
- Write latency 1: the new value is visible on `csr_rd_data` and on mtvec_o/mepc_o/mie_o the cycle after the strobe. Reading and writing the same CSR in one cycle returns the old value.
- The counter value read is the pre-increment value of the current cycle. mcycle read on two consecutive cycles differs by exactly 1.
- Trap and mret effects are visible on outputs one cycle after the request.

## Configuration
- `CSR_COUNTERS_EN` defined: mcycle, mcycleh, minstret and minstreth are implemented as described above.
- `CSR_COUNTERS_EN` undefined:
  - Counter registers are not synthesized and `instr_retire` is ignored.
  - Addresses 0xB00, 0xB02, 0xB80 and 0xB82 read 0.
  - Writes to these addresses are discarded and raise `illegal_csr`.

## Test plan
- Reset, then read every mapped address: mtvec=MTVEC_RESET & ~3, misa=MISA_VAL, mhartid=HART_ID; all others 0; illegal_csr=0.
- Write 0xFFFF_FFFF to mstatus, mtvec and mepc: reads return 0x0000_0088, 0xFFFF_FFFC and 0xFFFF_FFFC respectively. Write 0x1234 to 0x7C0: that address reads 0 and illegal_csr pulses for 1 cycle.
- Write mstatus=0x8; apply trap with cause=0xB, pc=0x104:
  - next cycle: mepc_o=0x104, mcause=0xB, mstatus=0x80, mie_o=0.
  - then mret: mstatus=0x88, mie_o=1.
- Write mcycle=0xFFFF_FFFE with mcycleh=0: two cycles later mcycle=0 and mcycleh=1.
- Hold instr_retire for 5 cycles while writing minstret=0x10 in cycle 3: minstret reads 0x12 after the burst.
- Assert trap and csr-write of mepc=0x200 in the same cycle, trap_pc=0x300: mepc=0x300. Build without CSR_COUNTERS_EN: 0xB00 reads 0 and writes raise illegal_csr.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR access port between the core and csr_file.
// The core (master) drives the strobe, address and write data; the register
// file (slave) returns the combinational read data for the addressed CSR.
interface csr_file_if;
  logic        csr;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;

  modport master (
    output csr,
    output csr_rd_addr,
    output csr_wr_data,
    input  csr_rd_data
  );

  modport slave (
    input  csr,
    input  csr_rd_addr,
    input  csr_wr_data,
    output csr_rd_data
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state (mstatus, mtvec, mepc, mcause, mscratch),
// read-only identity registers (misa, mhartid) and, when the CSR_COUNTERS_EN
// macro is defined, the 64-bit mcycle/minstret counters.
// Reads are a combinational mux on the address; writes land on the next edge.
// Priority on shared state: reset > trap > mret > CSR write > counter increment.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  csr_file_if.slave   bus,
  input  logic        instr_retire,
  input  logic        trap,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o,
  output logic        illegal_csr
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // mtvec and mepc keep only bits [31:2]; the low two bits always read 0.
  logic        mie_q;
  logic        mpie_q;
  logic [29:0] mtvec_q;
  logic [29:0] mepc_q;
  logic [31:0] mscratch_q;
  logic [31:0] mcause_q;
  logic        illegal_q;

  logic [31:0] rd_data;
  logic        writable;
  logic [31:0] cnt_rd;
  logic        cnt_hit;

  logic        wr_mstatus;
  logic        wr_mtvec;
  logic        wr_mscratch;
  logic        wr_mepc;
  logic        wr_mcause;

  assign wr_mstatus  = bus.csr && (bus.csr_rd_addr == A_MSTATUS);
  assign wr_mtvec    = bus.csr && (bus.csr_rd_addr == A_MTVEC);
  assign wr_mscratch = bus.csr && (bus.csr_rd_addr == A_MSCRATCH);
  assign wr_mepc     = bus.csr && (bus.csr_rd_addr == A_MEPC);
  assign wr_mcause   = bus.csr && (bus.csr_rd_addr == A_MCAUSE);

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycle_q;
  logic [31:0] mcycleh_q;
  logic [31:0] minstret_q;
  logic [31:0] minstreth_q;

  logic        wr_mcycle;
  logic        wr_mcycleh;
  logic        wr_minstret;
  logic        wr_minstreth;

  assign wr_mcycle    = bus.csr && (bus.csr_rd_addr == A_MCYCLE);
  assign wr_mcycleh   = bus.csr && (bus.csr_rd_addr == A_MCYCLEH);
  assign wr_minstret  = bus.csr && (bus.csr_rd_addr == A_MINSTRET);
  assign wr_minstreth = bus.csr && (bus.csr_rd_addr == A_MINSTRETH);

  // Counter read mux; cnt_hit marks the address as a writable counter half.
  always_comb begin
    cnt_rd  = '0;
    cnt_hit = 1'b1;
    case (bus.csr_rd_addr)
      A_MCYCLE:    cnt_rd = mcycle_q;
      A_MCYCLEH:   cnt_rd = mcycleh_q;
      A_MINSTRET:  cnt_rd = minstret_q;
      A_MINSTRETH: cnt_rd = minstreth_q;
      default:     cnt_hit = 1'b0;
    endcase
  end

  // Cycle counter: a write to either half replaces that half's update and suppresses the carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q  <= '0;
      mcycleh_q <= '0;
    end else begin
      if (wr_mcycle) mcycle_q <= bus.csr_wr_data;
      else           mcycle_q <= mcycle_q + 32'd1;
      if (wr_mcycleh)                   mcycleh_q <= bus.csr_wr_data;
      else if (!wr_mcycle && &mcycle_q) mcycleh_q <= mcycleh_q + 32'd1;
    end
  end

  // Retired-instruction counter, same write/carry rules, advancing only on instr_retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      minstret_q  <= '0;
      minstreth_q <= '0;
    end else begin
      if (wr_minstret)       minstret_q <= bus.csr_wr_data;
      else if (instr_retire) minstret_q <= minstret_q + 32'd1;
      if (wr_minstreth)
        minstreth_q <= bus.csr_wr_data;
      else if (!wr_minstret && instr_retire && &minstret_q)
        minstreth_q <= minstreth_q + 32'd1;
    end
  end
`else
  // Counters absent: their addresses fall through to the unmapped behaviour.
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
  assign cnt_rd  = '0;
  assign cnt_hit = 1'b0;
`endif

  // Read mux and write-legality decode for the addressed CSR.
  always_comb begin
    rd_data  = '0;
    writable = 1'b0;
    case (bus.csr_rd_addr)
      A_MSTATUS: begin
        rd_data  = {24'd0, mpie_q, 3'b000, mie_q, 3'b000};
        writable = 1'b1;
      end
      A_MISA:    rd_data = MISA_VAL;
      A_MTVEC: begin
        rd_data  = {mtvec_q, 2'b00};
        writable = 1'b1;
      end
      A_MSCRATCH: begin
        rd_data  = mscratch_q;
        writable = 1'b1;
      end
      A_MEPC: begin
        rd_data  = {mepc_q, 2'b00};
        writable = 1'b1;
      end
      A_MCAUSE: begin
        rd_data  = mcause_q;
        writable = 1'b1;
      end
      A_MHARTID: rd_data = HART_ID;
      default: begin
        rd_data  = cnt_rd;
        writable = cnt_hit;
      end
    endcase
  end

  // mstatus: trap stacks MIE into MPIE, mret restores it, else a CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (trap) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_mstatus) begin
      mie_q  <= bus.csr_wr_data[3];
      mpie_q <= bus.csr_wr_data[7];
    end
  end

  // mepc/mcause: trap capture overrides a same-cycle CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap) begin
      mepc_q   <= trap_pc[31:2];
      mcause_q <= trap_cause;
    end else begin
      if (wr_mepc)   mepc_q   <= bus.csr_wr_data[31:2];
      if (wr_mcause) mcause_q <= bus.csr_wr_data;
    end
  end

  // mtvec/mscratch: plain CSR-written registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
    end else begin
      if (wr_mtvec)    mtvec_q    <= bus.csr_wr_data[31:2];
      if (wr_mscratch) mscratch_q <= bus.csr_wr_data;
    end
  end

  // One-cycle flag for an access to a read-only or unmapped address.
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= bus.csr && !writable;
  end

  assign bus.csr_rd_data = rd_data;
  assign mtvec_o         = {mtvec_q, 2'b00};
  assign mepc_o          = {mepc_q, 2'b00};
  assign mie_o           = mie_q;
  assign illegal_csr     = illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with hand-computed values, then a
// randomized run, all checked every cycle against a behavioural model.
module tb_csr_file;

  localparam logic [31:0] HART = 32'h0000_0005;
  localparam logic [31:0] MTVR = 32'h0000_1003;
  localparam logic [31:0] MISA = 32'h4000_0100;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_retire;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;
  logic        illegal_csr;

  csr_file_if bus();

  csr_file #(.HART_ID(HART), .MTVEC_RESET(MTVR), .MISA_VAL(MISA)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .instr_retire (instr_retire),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .mret         (mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o),
    .illegal_csr  (illegal_csr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_ms, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;
  bit          m_ill;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_writable(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
      12'hB00, 12'hB02, 12'hB80, 12'hB82:          return CNT_EN;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_ms & 32'h88;
      12'h301: return MISA;
      12'h305: return m_mtvec & ~32'h3;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & ~32'h3;
      12'h342: return m_mcause;
      12'hB00: return CNT_EN ? m_cyc[31:0]  : 32'h0;
      12'hB80: return CNT_EN ? m_cyc[63:32] : 32'h0;
      12'hB02: return CNT_EN ? m_ret[31:0]  : 32'h0;
      12'hB82: return CNT_EN ? m_ret[63:32] : 32'h0;
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  // Model update on each rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    logic [11:0] a;
    logic [31:0] wd;
    bit          w;
    a  = bus.csr_rd_addr;
    wd = bus.csr_wr_data;
    w  = bus.csr;
    if (reset) begin
      m_ms = 0; m_mtvec = MTVR; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ret = 0; m_ill = 0;
    end else begin
      m_ill = w && !m_writable(a);
      if (w && a == 12'hB00)      m_cyc = {m_cyc[63:32], wd};
      else if (w && a == 12'hB80) m_cyc = {wd, m_cyc[31:0] + 32'd1};
      else                        m_cyc = m_cyc + 64'd1;
      if (w && a == 12'hB02)      m_ret = {m_ret[63:32], wd};
      else if (w && a == 12'hB82) m_ret = {wd, m_ret[31:0] + {31'd0, instr_retire}};
      else                        m_ret = m_ret + {63'd0, instr_retire};
      if (w && a == 12'h305) m_mtvec = wd;
      if (w && a == 12'h340) m_mscratch = wd;
      if (trap) begin
        m_mepc   = trap_pc;
        m_mcause = trap_cause;
        m_ms     = m_ms[3] ? 32'h80 : 32'h0;
      end else begin
        if (w && a == 12'h341) m_mepc = wd;
        if (w && a == 12'h342) m_mcause = wd;
        if (mret)                   m_ms = 32'h80 | (m_ms[7] ? 32'h8 : 32'h0);
        else if (w && a == 12'h300) m_ms = wd & 32'h88;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rd_data", bus.csr_rd_data, m_read(bus.csr_rd_addr));
      check("mtvec_o", mtvec_o, m_mtvec & ~32'h3);
      check("mepc_o", mepc_o, m_mepc & ~32'h3);
      check("mie_o", {31'd0, mie_o}, {31'd0, m_ms[3]});
      check("illegal_csr", {31'd0, illegal_csr}, {31'd0, m_ill});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr = 1'b1; bus.csr_rd_addr = a; bus.csr_wr_data = d;
    tick();
    bus.csr = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string nm);
    bus.csr = 1'b0; bus.csr_rd_addr = a;
    @(negedge clk);
    check(nm, bus.csr_rd_data, exp);
    tick();
  endtask

  logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0,
                              12'h000, 12'hFFF};

  initial begin
    reset = 1'b1; instr_retire = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0;
    bus.csr = 1'b0; bus.csr_rd_addr = '0; bus.csr_wr_data = '0;
    tick(); tick();
    cmp_en = 1'b1;

    // Reset state, read while reset is held so counters stay at 0
    peek(12'h305, 32'h0000_1000, "rst_mtvec");
    peek(12'h301, MISA, "rst_misa");
    peek(12'hF14, 32'h5, "rst_mhartid");
    peek(12'h300, 32'h0, "rst_mstatus");
    peek(12'h340, 32'h0, "rst_mscratch");
    peek(12'h341, 32'h0, "rst_mepc");
    peek(12'h342, 32'h0, "rst_mcause");
    peek(12'hB00, 32'h0, "rst_mcycle");
    peek(12'hB82, 32'h0, "rst_minstreth");
    @(negedge clk);
    check("rst_illegal", {31'd0, illegal_csr}, 32'h0);
    check("rst_mtvec_o", mtvec_o, 32'h0000_1000);
    check("rst_mepc_o", mepc_o, 32'h0);
    tick();
    reset = 1'b0;

    // Write masks
    wr(12'h300, 32'hFFFF_FFFF);
    wr(12'h305, 32'hFFFF_FFFF);
    wr(12'h341, 32'hFFFF_FFFF);
    peek(12'h300, 32'h0000_0088, "mask_mstatus");
    peek(12'h305, 32'hFFFF_FFFC, "mask_mtvec");
    peek(12'h341, 32'hFFFF_FFFC, "mask_mepc");

    // Unmapped write: reads 0, illegal pulses for exactly one cycle
    wr(12'h7C0, 32'h0000_1234);
    @(negedge clk);
    check("unmapped_rd", bus.csr_rd_data, 32'h0);
    check("illegal_pulse", {31'd0, illegal_csr}, 32'h1);
    tick();
    @(negedge clk);
    check("illegal_clear", {31'd0, illegal_csr}, 32'h0);
    tick();

    // Trap entry then mret
    wr(12'h300, 32'h0000_0008);
    trap = 1'b1; trap_cause = 32'hB; trap_pc = 32'h104;
    tick();
    trap = 1'b0; bus.csr_rd_addr = 12'h342;
    @(negedge clk);
    check("trap_mepc_o", mepc_o, 32'h104);
    check("trap_mcause", bus.csr_rd_data, 32'hB);
    check("trap_mie", {31'd0, mie_o}, 32'h0);
    tick();
    peek(12'h300, 32'h0000_0080, "trap_mstatus");
    mret = 1'b1;
    tick();
    mret = 1'b0; bus.csr_rd_addr = 12'h300;
    @(negedge clk);
    check("mret_mstatus", bus.csr_rd_data, 32'h0000_0088);
    check("mret_mie", {31'd0, mie_o}, 32'h1);
    tick();

    // Trap and CSR write to mepc in the same cycle: trap wins
    trap = 1'b1; trap_pc = 32'h300; trap_cause = 32'h7;
    bus.csr = 1'b1; bus.csr_rd_addr = 12'h341; bus.csr_wr_data = 32'h200;
    tick();
    trap = 1'b0; bus.csr = 1'b0;
    peek(12'h341, 32'h300, "trap_vs_wr_mepc");

    // Reset during a write drops the write
    bus.csr = 1'b1; bus.csr_rd_addr = 12'h340; bus.csr_wr_data = 32'hDEAD_BEEF;
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.csr = 1'b0;
    peek(12'h340, 32'h0, "reset_drops_wr");

`ifdef CSR_COUNTERS_EN
    // Carry from mcycle into mcycleh
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    bus.csr_rd_addr = 12'hB00;
    @(negedge clk);
    check("mcycle_pre", bus.csr_rd_data, 32'hFFFF_FFFF);
    tick();
    @(negedge clk);
    check("mcycle_wrap", bus.csr_rd_data, 32'h0);
    bus.csr_rd_addr = 12'hB80;
    #1;
    check("mcycleh_carry", bus.csr_rd_data, 32'h1);
    tick();

    // minstret write in the middle of a retire burst
    wr(12'hB02, 32'h0);
    instr_retire = 1'b1;
    tick(); tick();
    wr(12'hB02, 32'h10);
    tick(); tick();
    instr_retire = 1'b0;
    peek(12'hB02, 32'h12, "minstret_burst");
`else
    // Counters absent: address reads 0 and writes flag illegal
    wr(12'hB00, 32'h0000_5555);
    @(negedge clk);
    check("nocnt_rd", bus.csr_rd_data, 32'h0);
    check("nocnt_illegal", {31'd0, illegal_csr}, 32'h1);
    tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) == 0);
      bus.csr          = ($urandom_range(0, 2) == 0);
      bus.csr_rd_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 13)];
      bus.csr_wr_data  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
      instr_retire     = 1'($urandom_range(0, 1));
      trap             = ($urandom_range(0, 15) == 0);
      mret             = ($urandom_range(0, 15) == 0);
      trap_cause       = $urandom;
      trap_pc          = $urandom;
      tick();
    end

    reset = 1'b0; bus.csr = 1'b0; trap = 1'b0; mret = 1'b0; instr_retire = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
